// File: rtl/pit_data_match.sv
// Data-side PIT lookup: hash the Data prefix, read the slot, and on a valid entry
// clear it and forward the stored buffer address; otherwise drop as unsolicited.
module pit_data_match #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [63:0]      data_prefix,
  input  logic [4:0]       data_len,
  input  logic             tbl_busy,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [63:0]      tbl_rd_data,
  output logic             tbl_wr_en,
  output logic [63:0]      tbl_wr_data,
  output logic             fwd_valid,
  input  logic             fwd_ready,
  output logic [61:0]      fwd_addr,
  output logic             fwd_aggr,
  output logic             unsol,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, READ, CHECK, CLEAR, OUT, DROP} state_t;

  localparam int FOLD_N = (64 + IDX_W - 1) / IDX_W;
  localparam int PAD_W  = FOLD_N * IDX_W;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [61:0]      addr_reg;
  logic             aggr_reg;
  logic [CNT_W-1:0] match_cnt_reg;
  logic [CNT_W-1:0] drop_cnt_reg;

  // XOR-fold of the zero-padded prefix; must match the insertion-side hash.
  logic [PAD_W-1:0] prefix_pad;
  logic [IDX_W-1:0] fold_part [FOLD_N];

  assign prefix_pad = PAD_W'(data_prefix);

  generate
    for (genvar gi = 0; gi < FOLD_N; gi++) begin : g_fold
      if (gi == 0) begin : g_first
        assign fold_part[gi] = prefix_pad[IDX_W-1:0];
      end else begin : g_rest
        assign fold_part[gi] = fold_part[gi-1] ^ prefix_pad[gi*IDX_W +: IDX_W];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      addr_reg      <= '0;
      aggr_reg      <= 1'b0;
      match_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && data_valid) begin
        idx_reg <= fold_part[FOLD_N-1];
      end
      if (state_reg == CHECK && tbl_rd_data[63]) begin
        aggr_reg <= tbl_rd_data[62];
        addr_reg <= tbl_rd_data[61:0];
      end
      if (state_reg == OUT && fwd_ready && !(&match_cnt_reg)) begin
        match_cnt_reg <= match_cnt_reg + CNT_W'(1);
      end
      if (state_reg == DROP && !(&drop_cnt_reg)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Strobes are qualified by rst so an in-flight operation cannot touch the table
  // or signal downstream during the reset cycle.
  always_comb begin
    state_next = state_reg;
    data_ready = 1'b0;
    tbl_rd_en  = 1'b0;
    tbl_wr_en  = 1'b0;
    fwd_valid  = 1'b0;
    unsol      = 1'b0;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          data_ready = 1'b1;
          if (data_valid) begin
            state_next = (data_len == 5'd0) ? DROP : READ;
          end
        end
        READ: begin
          if (!tbl_busy) begin
            tbl_rd_en  = 1'b1;
            state_next = CHECK;
          end
        end
        CHECK: begin
          state_next = tbl_rd_data[63] ? CLEAR : DROP;
        end
        CLEAR: begin
          if (!tbl_busy) begin
            tbl_wr_en  = 1'b1;
            state_next = OUT;
          end
        end
        OUT: begin
          fwd_valid = 1'b1;
          if (fwd_ready) begin
            state_next = IDLE;
          end
        end
        DROP: begin
          unsol      = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign tbl_addr    = idx_reg;
  assign tbl_wr_data = 64'd0;
  assign fwd_addr    = addr_reg;
  assign fwd_aggr    = aggr_reg;
  assign match_cnt   = match_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_pit_data_match.sv
// Directed bench for pit_data_match: a behavioural PIT table, a scoreboard of
// expected forward/drop results, and per-packet latency checks.
module tb_pit_data_match;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [63:0] data_prefix = 64'd0;
  logic [4:0]  data_len = 5'd0;
  logic        tbl_busy = 1'b0;
  logic        tbl_rd_en;
  logic [9:0]  tbl_addr;
  logic [63:0] tbl_rd_data;
  logic        tbl_wr_en;
  logic [63:0] tbl_wr_data;
  logic        fwd_valid;
  logic        fwd_ready = 1'b0;
  logic [61:0] fwd_addr;
  logic        fwd_aggr;
  logic        unsol;
  logic [15:0] match_cnt;
  logic [15:0] drop_cnt;

  // Second instance with narrow counters so saturation is reachable quickly.
  logic        s_valid = 1'b0;
  logic        s_ready, s_rd_en, s_wr_en, s_fwd_valid, s_fwd_aggr, s_unsol;
  logic [9:0]  s_addr;
  logic [63:0] s_wr_data;
  logic [61:0] s_fwd_addr;
  logic [4:0]  s_match_cnt, s_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pit_data_match dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(data_ready),
    .data_prefix(data_prefix), .data_len(data_len), .tbl_busy(tbl_busy),
    .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_rd_data(tbl_rd_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_data(tbl_wr_data), .fwd_valid(fwd_valid),
    .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_aggr(fwd_aggr),
    .unsol(unsol), .match_cnt(match_cnt), .drop_cnt(drop_cnt)
  );

  pit_data_match #(.IDX_W(10), .CNT_W(5)) sat (
    .clk(clk), .rst(rst), .data_valid(s_valid), .data_ready(s_ready),
    .data_prefix(64'd0), .data_len(5'd0), .tbl_busy(1'b0),
    .tbl_rd_en(s_rd_en), .tbl_addr(s_addr), .tbl_rd_data(64'd0),
    .tbl_wr_en(s_wr_en), .tbl_wr_data(s_wr_data), .fwd_valid(s_fwd_valid),
    .fwd_ready(1'b0), .fwd_addr(s_fwd_addr), .fwd_aggr(s_fwd_aggr),
    .unsol(s_unsol), .match_cnt(s_match_cnt), .drop_cnt(s_drop_cnt)
  );

  // Behavioural PIT: registered read, synchronous write, bench-side preload port.
  logic [63:0] mem [1024];
  logic [63:0] rd_q = 64'd0;
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [63:0] pre_val = 64'd0;

  always @(posedge clk) begin
    if (tbl_rd_en) rd_q <= mem[tbl_addr];
    if (tbl_wr_en) mem[tbl_addr] <= tbl_wr_data;
    if (pre_en) mem[pre_idx] <= pre_val;
  end
  assign tbl_rd_data = rd_q;

  typedef struct packed {
    logic        is_match;
    logic [61:0] addr;
    logic        aggr;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sb_check(input logic is_match);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got %s expected nothing", is_match ? "match" : "drop");
    end else begin
      e = sb_q.pop_front();
      chk("sb_kind", 64'(is_match), 64'(e.is_match));
      if (is_match) begin
        chk("sb_fwd_addr", 64'(fwd_addr), 64'(e.addr));
        chk("sb_fwd_aggr", 64'(fwd_aggr), 64'(e.aggr));
      end
      $display("monitor: %s addr=%h aggr=%0d", is_match ? "match" : "drop", fwd_addr, fwd_aggr);
    end
  endtask

  // Monitor: decoupled from stimulus, consumes one expectation per DUT result.
  always @(negedge clk) begin
    if (rst) begin
      if (fwd_valid && fwd_ready) sb_check(1'b1);
      if (unsol) sb_check(1'b0);
      if (tbl_rd_en && tbl_wr_en) chk("rd_wr_exclusive", 64'd1, 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [63:0] val);
    cyc();
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    cyc();
    pre_en = 1'b0;
  endtask

  // First-occurrence offsets (cycles after the accept cycle T), -1 if never seen.
  int t_rd, t_wr, t_fv, t_un, t_rdy, n_wr;

  task automatic pkt(input logic [63:0] p, input logic [4:0] len, input logic [31:0] busy_m,
                     input logic [31:0] rdy_m, input int n, input logic [9:0] exp_idx);
    logic [61:0] fa;
    bit seen;
    fa = '0; seen = 0;
    t_rd = -1; t_wr = -1; t_fv = -1; t_un = -1; t_rdy = -1; n_wr = 0;
    cyc();
    data_valid = 1'b1; data_prefix = p; data_len = len;
    tbl_busy = busy_m[0]; fwd_ready = rdy_m[0];
    @(negedge clk);
    chk("accept_ready", 64'(data_ready), 64'd1);
    for (int k = 1; k <= n; k++) begin
      cyc();
      data_valid = 1'b0; tbl_busy = busy_m[k]; fwd_ready = rdy_m[k];
      @(negedge clk);
      if (tbl_rd_en && t_rd < 0) t_rd = k;
      if (tbl_wr_en) begin
        n_wr++;
        if (t_wr < 0) t_wr = k;
        chk("wr_data_zero", tbl_wr_data, 64'd0);
      end
      if (tbl_rd_en || tbl_wr_en) chk("tbl_addr", 64'(tbl_addr), 64'(exp_idx));
      if (fwd_valid) begin
        if (t_fv < 0) t_fv = k;
        if (seen) chk("fwd_addr_hold", 64'(fwd_addr), 64'(fa));
        fa = fwd_addr; seen = 1;
        chk("ready_low_in_out", 64'(data_ready), 64'd0);
      end
      if (unsol && t_un < 0) t_un = k;
      if (data_ready && t_rdy < 0) t_rdy = k;
    end
    tbl_busy = 1'b0;
    $display("pkt prefix=%h len=%0d rd@%0d wr@%0d fwd@%0d unsol@%0d idle@%0d",
             p, len, t_rd, t_wr, t_fv, t_un, t_rdy);
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_unsol", 64'(unsol), 64'd0);
    chk("rst_rd_wr", 64'({tbl_rd_en, tbl_wr_en}), 64'd0);
    chk("rst_counters", 64'({match_cnt, drop_cnt}), 64'd0);
    chk("rst_fwd_addr", 64'(fwd_addr), 64'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("release_ready", 64'(data_ready), 64'd1);

    // Hit at slot 0x005
    preload(10'h005, {1'b1, 1'b0, 62'h400});
    sb_q.push_back('{1'b1, 62'h400, 1'b0});
    pkt(64'h5, 5'd8, 32'h0, 32'hFFFF_FFFF, 6, 10'h005);
    chk_int("hit_t_rd", t_rd, 1);
    chk_int("hit_t_wr", t_wr, 3);
    chk_int("hit_t_fv", t_fv, 4);
    chk_int("hit_t_idle", t_rdy, 5);
    chk_int("hit_t_unsol", t_un, -1);
    chk("hit_match_cnt", 64'(match_cnt), 64'd1);
    chk("hit_slot_cleared", mem[5], 64'd0);

    // Miss on the now-cleared slot
    sb_q.push_back('{1'b0, 62'h0, 1'b0});
    pkt(64'h5, 5'd8, 32'h0, 32'hFFFF_FFFF, 6, 10'h005);
    chk_int("miss_t_rd", t_rd, 1);
    chk_int("miss_t_unsol", t_un, 3);
    chk_int("miss_n_wr", n_wr, 0);
    chk_int("miss_t_fv", t_fv, -1);
    chk_int("miss_t_idle", t_rdy, 4);
    chk("miss_drop_cnt", 64'(drop_cnt), 64'd1);

    // Malformed: dropped without table access
    sb_q.push_back('{1'b0, 62'h0, 1'b0});
    pkt(64'h5, 5'd0, 32'h0, 32'hFFFF_FFFF, 3, 10'h005);
    chk_int("malf_t_unsol", t_un, 1);
    chk_int("malf_t_rd", t_rd, -1);
    chk_int("malf_t_idle", t_rdy, 2);
    chk("malf_drop_cnt", 64'(drop_cnt), 64'd2);

    // Aggregated entry
    preload(10'h123, {1'b1, 1'b1, 62'h800});
    sb_q.push_back('{1'b1, 62'h800, 1'b1});
    pkt(64'h123, 5'd4, 32'h0, 32'hFFFF_FFFF, 6, 10'h123);
    chk_int("aggr_t_fv", t_fv, 4);
    chk("aggr_match_cnt", 64'(match_cnt), 64'd2);

    // Stalls (busy T+1..3 in READ, T+6..7 in CLEAR) and backpressure T+9..12.
    // Prefix folds to 0x001 ^ 0x002 ^ 0x00F = 0x00C.
    preload(10'h00C, {1'b1, 1'b0, 62'h1234});
    sb_q.push_back('{1'b1, 62'h1234, 1'b0});
    pkt(64'hF000_0000_0000_0801, 5'd16, 32'h0000_00CE, 32'hFFFF_E1FF, 16, 10'h00C);
    chk_int("stall_t_rd", t_rd, 4);
    chk_int("stall_t_wr", t_wr, 8);
    chk_int("stall_n_wr", n_wr, 1);
    chk_int("stall_t_fv", t_fv, 9);
    chk_int("stall_t_idle", t_rdy, 14);
    chk("stall_match_cnt", 64'(match_cnt), 64'd3);
    chk("stall_slot_cleared", mem[12], 64'd0);

    // Reset while in CLEAR
    preload(10'h005, {1'b1, 1'b0, 62'h77});
    pkt(64'h5, 5'd8, 32'h0, 32'hFFFF_FFFF, 2, 10'h005);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_no_write", 64'(tbl_wr_en), 64'd0);
    chk("rstmid_outputs", 64'({fwd_valid, unsol, data_ready}), 64'd0);
    cyc();
    @(negedge clk);
    chk("rstmid_counters", 64'({match_cnt, drop_cnt}), 64'd0);
    chk("rstmid_fwd", 64'({fwd_aggr, fwd_addr}), 64'd0);
    chk("rstmid_tbl_addr", 64'(tbl_addr), 64'd0);
    chk("rstmid_slot_kept", mem[5], {1'b1, 1'b0, 62'h77});
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready_after", 64'(data_ready), 64'd1);

    // Saturation of the narrow-counter instance (~40 drops into a 5-bit counter)
    cyc();
    s_valid = 1'b1;
    repeat (80) cyc();
    @(negedge clk);
    chk("sat_drop_cnt", 64'(s_drop_cnt), 64'h1F);
    chk("sat_match_cnt", 64'(s_match_cnt), 64'd0);
    s_valid = 1'b0;

    repeat (3) cyc();
    chk_int("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
